exhaustive_response_checker: RTL and testbench

- Synthesizable stimulus-and-check stage that exercises a small combinational DUT through every input combination.
- Drives a WIDTH-bit exhaustive pattern counter onto the DUT inputs and samples the single-bit DUT response after a programmable settle time.
- Compares each response against a parameterised truth table and reports mismatch count, first failing pattern, and pass/done status.
- Replaces free-running `#10` delay loops with a clocked, self-checking sequencer usable in simulation and on hardware.

---
 rtl/exhaustive_response_checker_if.sv | 42 ++++
 rtl/exhaustive_response_checker.sv | 178 +++++++++++++++++
 tb/tb_exhaustive_response_checker.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/exhaustive_response_checker_if.sv
// -----------------------------------------------------------------------------
// exhaustive_response_checker_if
//
// Purpose : groups the sequencer's control, stimulus and status signals into
//           one bundle. The checker attaches through the master modport; the
//           environment side (the DUT model and the run controller) attaches
//           through the slave modport.
//
// Signals :
//   start             control -> checker  single-cycle run request
//   pattern[W-1:0]    checker -> DUT      stimulus (bit0=a, bit1=b, bit2=c)
//   dut_out           DUT -> checker      response to pattern
//   busy              checker -> env      run in progress
//   done              checker -> env      run finished, held until next start
//   pass              checker -> env      valid while done, 1 iff no errors
//   err_count[W:0]    checker -> env      number of mismatching patterns
//   first_fail[W-1:0] checker -> env      pattern of the first mismatch
//   first_fail_valid  checker -> env      first_fail holds a captured value
// -----------------------------------------------------------------------------
interface exhaustive_response_checker_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] pattern;
  logic             dut_out;
  logic             busy;
  logic             done;
  logic             pass;
  logic [WIDTH:0]   err_count;
  logic [WIDTH-1:0] first_fail;
  logic             first_fail_valid;

  modport master (
    input  start, dut_out,
    output pattern, busy, done, pass, err_count, first_fail, first_fail_valid
  );

  modport slave (
    output start, dut_out,
    input  pattern, busy, done, pass, err_count, first_fail, first_fail_valid
  );
endinterface

// File: rtl/exhaustive_response_checker.sv
// -----------------------------------------------------------------------------
// exhaustive_response_checker
//
// Purpose : clocked stimulus-and-check sequencer. On start it walks a WIDTH-bit
//           pattern counter through all 2**WIDTH values, holds each value for
//           SETTLE+1 cycles, samples the DUT response on the last cycle of the
//           hold and compares it with bit <pattern> of the EXPECT truth table.
//           It reports the mismatch count, the first failing pattern and a
//           pass/done status. All outputs come straight from registers.
//
// Ports   :
//   clk   input   system clock, rising edge
//   rst   input   synchronous, active-high reset (wins over start)
//   bus   master  exhaustive_response_checker_if (start, pattern, dut_out,
//                 busy, done, pass, err_count, first_fail, first_fail_valid)
//                 The interface WIDTH must equal this module's WIDTH.
//
// Parameters:
//   WIDTH  number of DUT inputs
//   SETTLE extra hold cycles per pattern before sampling
//   EXPECT truth table, bit n = expected dut_out for pattern n
//
// Build option:
//   STOP_ON_FAIL_EN  when defined, the run ends at the first mismatch with
//                    pattern frozen on the failing value.
// -----------------------------------------------------------------------------
module exhaustive_response_checker #(
  parameter int                    WIDTH  = 3,
  parameter int                    SETTLE = 0,
  parameter logic [2**WIDTH-1:0]   EXPECT = 8'h96
) (
  input logic                          clk,
  input logic                          rst,
  exhaustive_response_checker_if.master bus
);

  localparam int CW = WIDTH + 1;
  // Hold counter must be able to represent SETTLE; keep at least one bit.
  localparam int HW = (SETTLE > 0) ? $clog2(SETTLE + 1) : 1;
  localparam logic [WIDTH-1:0] LAST_PATTERN = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HOLD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pattern_q, pattern_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [CW-1:0]    err_q, err_d;
  logic [WIDTH-1:0] ff_q, ff_d;
  logic             ffv_q, ffv_d;

  logic             mismatch;
  logic [CW-1:0]    err_inc;

  // Only meaningful on a sampling edge; ignored elsewhere.
  assign mismatch = (bus.dut_out != EXPECT[pattern_q]);
  assign err_inc  = err_q + CW'(1);

  always_comb begin
    // NOTE: every next-state signal gets its hold value first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d   = state_q;
    pattern_d = pattern_q;
    hold_d    = hold_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    err_d     = err_q;
    ff_d      = ff_q;
    ffv_d     = ffv_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          state_d   = S_HOLD;
          pattern_d = '0;
          hold_d    = HW'(SETTLE);
          busy_d    = 1'b1;
          done_d    = 1'b0;
          pass_d    = 1'b0;
          err_d     = '0;
          ff_d      = '0;
          ffv_d     = 1'b0;
        end
      end

      S_HOLD: begin
        if (hold_q != '0) begin
          hold_d = hold_q - 1'b1;
        end else begin
          // Sampling edge.
          if (mismatch) begin
            err_d = err_inc;
            if (!ffv_q) begin
              ff_d  = pattern_q;
              ffv_d = 1'b1;
            end
          end
`ifdef STOP_ON_FAIL_EN
          if (mismatch) begin
            // Abort: freeze pattern on the failing value.
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = 1'b0;
          end else if (pattern_q == LAST_PATTERN) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pattern_d = '0;
            pass_d    = (err_q == '0);
          end else begin
            pattern_d = pattern_q + 1'b1;
            hold_d    = HW'(SETTLE);
          end
`else
          if (pattern_q == LAST_PATTERN) begin
            state_d   = S_DONE;
            busy_d    = 1'b0;
            done_d    = 1'b1;
            pattern_d = '0;
            // Includes this final comparison.
            pass_d    = (err_q == '0) && !mismatch;
          end else begin
            pattern_d = pattern_q + 1'b1;
            hold_d    = HW'(SETTLE);
          end
`endif
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pattern_q <= '0;
      hold_q    <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      err_q     <= '0;
      ff_q      <= '0;
      ffv_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      err_q     <= err_d;
      ff_q      <= ff_d;
      ffv_q     <= ffv_d;
    end
  end

  assign bus.pattern          = pattern_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail       = ff_q;
  assign bus.first_fail_valid = ffv_q;

endmodule

// File: tb/tb_exhaustive_response_checker.sv
// -----------------------------------------------------------------------------
// tb_exhaustive_response_checker
//
// Two checker instances: dut_a with default parameters (parity DUT model that
// can be forced stuck-at-0) and dut_b with SETTLE=2. Each started run pushes
// its hand-computed end-of-run result into a per-instance queue; a monitor per
// instance pops and compares whenever done rises. Inputs are driven on the
// falling edge; outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_exhaustive_response_checker;

  localparam int W = 3;

  typedef struct {
    int             done_cyc;
    logic [W:0]     err;
    logic [W-1:0]   ff;
    logic           ffv;
    logic           pass;
    logic [W-1:0]   pat;
  } exp_t;

  logic clk;
  logic rst;
  logic stuck_a;
  int   cyc;
  int   checks;
  int   errors;

  exp_t exp_a[$];
  exp_t exp_b[$];

  exhaustive_response_checker_if #(.WIDTH(W)) if_a ();
  exhaustive_response_checker_if #(.WIDTH(W)) if_b ();

  exhaustive_response_checker #(.WIDTH(W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (if_a.master)
  );

  exhaustive_response_checker #(.WIDTH(W), .SETTLE(2)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (if_b.master)
  );

  // Combinational DUT models: 3-input odd parity, optionally stuck at 0.
  assign if_a.dut_out = stuck_a ? 1'b0 : ^if_a.pattern;
  assign if_b.dut_out = ^if_b.pattern;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return {if_a.pattern, if_a.busy, if_a.done, if_a.pass,
            if_a.err_count, if_a.first_fail, if_a.first_fail_valid};
  endfunction

  function automatic logic [31:0] outs_b();
    return {if_b.pattern, if_b.busy, if_b.done, if_b.pass,
            if_b.err_count, if_b.first_fail, if_b.first_fail_valid};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- monitors ----------------
  logic done_a_prev = 1'b0;
  logic done_b_prev = 1'b0;

  always @(negedge clk) begin
    if (if_a.done === 1'b1 && done_a_prev !== 1'b1) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_a.pop_front();
        check("a_done_cycle", cyc,            e.done_cyc);
        check("a_busy",       if_a.busy,      0);
        check("a_err_count",  if_a.err_count, e.err);
        check("a_first_fail", if_a.first_fail, e.ff);
        check("a_ff_valid",   if_a.first_fail_valid, e.ffv);
        check("a_pass",       if_a.pass,      e.pass);
        check("a_pattern",    if_a.pattern,   e.pat);
      end
    end
    done_a_prev <= if_a.done;
  end

  always @(negedge clk) begin
    if (if_b.done === 1'b1 && done_b_prev !== 1'b1) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = exp_b.pop_front();
        check("b_done_cycle", cyc,            e.done_cyc);
        check("b_busy",       if_b.busy,      0);
        check("b_err_count",  if_b.err_count, e.err);
        check("b_first_fail", if_b.first_fail, e.ff);
        check("b_ff_valid",   if_b.first_fail_valid, e.ffv);
        check("b_pass",       if_b.pass,      e.pass);
        check("b_pattern",    if_b.pattern,   e.pat);
      end
    end
    done_b_prev <= if_b.done;
  end

  // ---------------- stimulus ----------------
  initial begin
    int   t0;
    exp_t e;
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    stuck_a    = 1'b0;
    if_a.start = 1'b0;
    if_b.start = 1'b0;

    // Test 1: reset, then idle.
    tick(2);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(1);
      check("idle_a_outputs", outs_a(), 0);
    end
    check("idle_b_outputs", outs_b(), 0);

    // Test 2: correct model, full run.
    if_a.start = 1'b1;
    t0 = cyc + 1;
    e = '{done_cyc: t0 + 8, err: 0, ff: 0, ffv: 0, pass: 1, pat: 0};
    exp_a.push_back(e);
    tick(1);
    if_a.start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      check("t2_pattern", if_a.pattern, n);
      check("t2_busy",    if_a.busy,    1);
      tick(1);
    end
    tick(2);

    // Test 3: stuck-at-0 response.
    stuck_a    = 1'b1;
    if_a.start = 1'b1;
    t0 = cyc + 1;
`ifdef STOP_ON_FAIL_EN
    e = '{done_cyc: t0 + 2, err: 1, ff: 1, ffv: 1, pass: 0, pat: 1};
`else
    e = '{done_cyc: t0 + 8, err: 4, ff: 1, ffv: 1, pass: 0, pat: 0};
`endif
    exp_a.push_back(e);
    tick(1);
    if_a.start = 1'b0;
    check("t3_start_clears_done", if_a.done, 0);
    tick(10);
    stuck_a = 1'b0;

    // Test 4: SETTLE=2, starts during busy are ignored.
    if_b.start = 1'b1;
    t0 = cyc + 1;
    e = '{done_cyc: t0 + 24, err: 0, ff: 0, ffv: 0, pass: 1, pat: 0};
    exp_b.push_back(e);
    tick(1);
    if_b.start = 1'b0;
    for (int n = 0; n < 24; n++) begin
      check("t4_pattern", if_b.pattern, n / 3);
      if (n == 4 || n == 9)  if_b.start = 1'b1;
      if (n == 5 || n == 10) if_b.start = 1'b0;
      tick(1);
    end
    tick(2);

    // Test 5: reset mid-run, then a fresh run.
    if_a.start = 1'b1;
    t0 = cyc + 1;
    tick(1);
    if_a.start = 1'b0;
    tick(3);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("t5_reset_outputs", outs_a(), 0);
    if_a.start = 1'b1;
    t0 = cyc + 1;
    e = '{done_cyc: t0 + 8, err: 0, ff: 0, ffv: 0, pass: 1, pat: 0};
    exp_a.push_back(e);
    tick(1);
    if_a.start = 1'b0;
    tick(12);

    // Any expectation still queued means a run never reported done.
    check("pending_a", exp_a.size(), 0);
    check("pending_b", exp_b.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
